level_sequencer: RTL and testbench

- Top-level game controller that owns the per-level datapaths (LV1..LVn).
- Sequences title -> play -> death/retry -> level-complete -> next level -> win.
- Holds every inactive level in reset, gates the jump key to the active level only, and muxes the active level's RGB onto the VGA path.
- Keeps an attempt counter and drives the death-flash and level-transition timing off the frame tick.

---
 rtl/level_sequencer_if.sv | 12 +
 rtl/level_sequencer.sv | 98 +++++++++
 tb/tb_level_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/level_sequencer_if.sv
// level_sequencer_if: sequencer<->level bus; master drives lv_rst/lv_jump/lv_sel, levels drive lv_cp/lv_death/lv_color
interface level_sequencer_if #(parameter int NUM_LV = 3, parameter int cA = 4);
  localparam int LSW = NUM_LV > 1 ? $clog2(NUM_LV) : 1;
  logic [NUM_LV-1:0] lv_cp;
  logic [NUM_LV-1:0] lv_death;
  logic [NUM_LV*3*cA-1:0] lv_color;
  logic [NUM_LV-1:0] lv_rst;
  logic lv_jump;
  logic [LSW-1:0] lv_sel;
  modport master(input lv_cp, lv_death, lv_color, output lv_rst, lv_jump, lv_sel);
  modport slave(output lv_cp, lv_death, lv_color, input lv_rst, lv_jump, lv_sel);
endinterface

// File: rtl/level_sequencer.sv
// level_sequencer: game FSM over NUM_LV levels; in clk/rst/imgReturn/jump/restart, level bus lv, out color/attempts/state_o
module level_sequencer #(
  parameter int cA = 4,
  parameter int NUM_LV = 3,
  parameter int DEATH_FRAMES = 30,
  parameter int DONE_FRAMES = 60,
  parameter int ATT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic imgReturn,
  input  logic jump,
  input  logic restart,
  level_sequencer_if.master lv,
  output logic [cA-1:0] color [2:0],
  output logic [ATT_W-1:0] attempts,
  output logic [2:0] state_o
);
  localparam int LSW = NUM_LV > 1 ? $clog2(NUM_LV) : 1;
  localparam int FMAX = DEATH_FRAMES > DONE_FRAMES ? DEATH_FRAMES : DONE_FRAMES;
  localparam int FCW = $clog2(FMAX + 1) < 3 ? 3 : $clog2(FMAX + 1);
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, DEAD, DONE, WIN} state_t;
  state_t st, st_n;
  logic [LSW-1:0] sel, sel_n;
  logic [ATT_W-1:0] att_n, att_inc;
  logic [FCW-1:0] fc, fc_n;
  logic [3*cA-1:0] slice, rgb_n;
  logic [NUM_LV-1:0] lvr_n;
  logic jmp_n;
  assign att_inc = &attempts ? attempts : attempts + ATT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      sel <= '0;
      attempts <= '0;
      fc <= '0;
      lv.lv_rst <= '1;
      lv.lv_jump <= 1'b0;
      color <= '{default: '0};
    end else begin
      st <= st_n;
      sel <= sel_n;
      attempts <= att_n;
      fc <= fc_n;
      lv.lv_rst <= lvr_n;
      lv.lv_jump <= jmp_n;
      color[2] <= rgb_n[3*cA-1 -: cA];
      color[1] <= rgb_n[2*cA-1 -: cA];
      color[0] <= rgb_n[cA-1:0];
    end
  end
  always_comb begin
    st_n = st;
    sel_n = sel;
    att_n = attempts;
    case (st)
      IDLE: if (jump) begin
        st_n = LOAD;
        sel_n = '0;
        att_n = ATT_W'(1);
      end
      LOAD: if (imgReturn) st_n = PLAY;
      PLAY: if (restart) begin
        st_n = LOAD;
        att_n = att_inc;
      end else if (lv.lv_death[sel]) st_n = DEAD;
      else if (lv.lv_cp[sel]) st_n = DONE;
      DEAD: if (restart || (imgReturn && fc == FCW'(DEATH_FRAMES - 1))) begin
        st_n = LOAD;
        att_n = att_inc;
      end
      DONE: if (restart) begin
        st_n = LOAD;
        att_n = att_inc;
      end else if (imgReturn && fc == FCW'(DONE_FRAMES - 1)) begin
        st_n = sel == LSW'(NUM_LV - 1) ? WIN : LOAD;
        sel_n = sel == LSW'(NUM_LV - 1) ? sel : sel + LSW'(1);
      end
      WIN: if (jump || restart) begin
        st_n = IDLE;
        sel_n = '0;
      end
      default: st_n = IDLE;
    endcase
    fc_n = st_n != st ? '0 : (imgReturn && (st == DEAD || st == DONE)) ? fc + FCW'(1) : fc;
  end
  // outputs are registered from next-state values so they line up with state_o
  always_comb begin
    slice = lv.lv_color[int'(sel_n)*3*cA +: 3*cA];
    rgb_n = st_n == WIN ? '1 :
            (st_n == DEAD && fc_n[2]) ? {{cA{1'b1}}, {2*cA{1'b0}}} :
            (st_n == PLAY || st_n == DEAD || st_n == DONE) ? slice : '0;
    lvr_n = st_n == PLAY ? ~(NUM_LV'(1) << sel_n) : '1;
    jmp_n = jump && st == PLAY;
  end
  assign lv.lv_sel = sel;
  assign state_o = st;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed self-checking bench for level_sequencer
module tb_level_sequencer;
  logic clk = 0, rst = 0, imgReturn = 0, jump = 0, restart = 0;
  logic [3:0] color [2:0];
  logic [1:0] attempts;
  logic [2:0] state_o;
  logic [11:0] rgb;
  int total = 0, bad = 0;
  level_sequencer_if #(.NUM_LV(3), .cA(4)) lv();
  level_sequencer #(.cA(4), .NUM_LV(3), .DEATH_FRAMES(30), .DONE_FRAMES(60), .ATT_W(2)) dut (
    .clk(clk), .rst(rst), .imgReturn(imgReturn), .jump(jump), .restart(restart),
    .lv(lv.master), .color(color), .attempts(attempts), .state_o(state_o));
  always #5 clk = ~clk;
  assign rgb = {color[2], color[1], color[0]};
  initial begin
    lv.lv_cp = '0;
    lv.lv_death = '0;
    lv.lv_color = {12'h3C5, 12'h2B4, 12'h1A3};
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic frame();
    imgReturn = 1; step(); imgReturn = 0; step();
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask
  task automatic test_reset();
    rst = 1; step(); rst = 0;
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
    total++; if (attempts !== 2'd0) begin bad++; $display("FAIL reset_att got=%0d want=0", attempts); end
    total++; if (lv.lv_rst !== 3'b111) begin bad++; $display("FAIL reset_lvrst got=%b want=111", lv.lv_rst); end
    total++; if (rgb !== 12'h000 || lv.lv_jump !== 1'b0 || lv.lv_sel !== 2'd0) begin bad++; $display("FAIL reset_out got=%h/%b/%0d want=000/0/0", rgb, lv.lv_jump, lv.lv_sel); end
  endtask
  task automatic test_start();
    restart = 1; step(); restart = 0;
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL idle_restart got=%0d want=0", state_o); end
    jump = 1; step(); jump = 0;
    total++; if (state_o !== 3'd1 || attempts !== 2'd1) begin bad++; $display("FAIL start_load got=%0d/%0d want=1/1", state_o, attempts); end
    step();
    total++; if (state_o !== 3'd1 || lv.lv_rst !== 3'b111) begin bad++; $display("FAIL load_wait got=%0d/%b want=1/111", state_o, lv.lv_rst); end
    frame();
    total++; if (state_o !== 3'd2 || lv.lv_rst !== 3'b110) begin bad++; $display("FAIL play_entry got=%0d/%b want=2/110", state_o, lv.lv_rst); end
    total++; if (rgb !== 12'h1A3 || lv.lv_sel !== 2'd0) begin bad++; $display("FAIL play_color got=%h/%0d want=1a3/0", rgb, lv.lv_sel); end
    jump = 1; step(); jump = 0;
    total++; if (lv.lv_jump !== 1'b1) begin bad++; $display("FAIL play_jump got=%b want=1", lv.lv_jump); end
    step();
    total++; if (lv.lv_jump !== 1'b0) begin bad++; $display("FAIL jump_clear got=%b want=0", lv.lv_jump); end
  endtask
  task automatic test_death();
    lv.lv_death = 3'b001; step(); lv.lv_death = 0;
    total++; if (state_o !== 3'd3 || rgb !== 12'h1A3 || lv.lv_rst !== 3'b111) begin bad++; $display("FAIL dead_entry got=%0d/%h/%b want=3/1a3/111", state_o, rgb, lv.lv_rst); end
    frames(3);
    total++; if (rgb !== 12'h1A3) begin bad++; $display("FAIL flash_f3 got=%h want=1a3", rgb); end
    frame();
    total++; if (rgb !== 12'hF00) begin bad++; $display("FAIL flash_f4 got=%h want=f00", rgb); end
    frames(3);
    total++; if (rgb !== 12'hF00) begin bad++; $display("FAIL flash_f7 got=%h want=f00", rgb); end
    frame();
    total++; if (rgb !== 12'h1A3) begin bad++; $display("FAIL flash_f8 got=%h want=1a3", rgb); end
    jump = 1; step(); jump = 0;
    total++; if (lv.lv_jump !== 1'b0 || state_o !== 3'd3) begin bad++; $display("FAIL dead_jump got=%b/%0d want=0/3", lv.lv_jump, state_o); end
    frames(21);
    total++; if (state_o !== 3'd3) begin bad++; $display("FAIL dead_f29 got=%0d want=3", state_o); end
    frame();
    total++; if (state_o !== 3'd1 || attempts !== 2'd2 || lv.lv_rst[0] !== 1'b1) begin bad++; $display("FAIL dead_retry got=%0d/%0d/%b want=1/2/1", state_o, attempts, lv.lv_rst[0]); end
    frame();
  endtask
  task automatic test_priority();
    lv.lv_death = 3'b010; lv.lv_cp = 3'b100; step(); lv.lv_death = 0; lv.lv_cp = 0;
    total++; if (state_o !== 3'd2) begin bad++; $display("FAIL other_level got=%0d want=2", state_o); end
    lv.lv_death = 3'b001; lv.lv_cp = 3'b001; step(); lv.lv_death = 0; lv.lv_cp = 0;
    total++; if (state_o !== 3'd3) begin bad++; $display("FAIL death_beats_cp got=%0d want=3", state_o); end
    restart = 1; step(); restart = 0;
    total++; if (state_o !== 3'd1 || attempts !== 2'd3) begin bad++; $display("FAIL dead_restart got=%0d/%0d want=1/3", state_o, attempts); end
  endtask
  task automatic test_saturate();
    frame();
    restart = 1; step(); restart = 0;
    total++; if (state_o !== 3'd1 || attempts !== 2'd3 || lv.lv_sel !== 2'd0) begin bad++; $display("FAIL play_restart got=%0d/%0d/%0d want=1/3/0", state_o, attempts, lv.lv_sel); end
    for (int i = 0; i < 3; i++) begin
      frame();
      lv.lv_death = 3'b001; step(); lv.lv_death = 0;
      restart = 1; step(); restart = 0;
    end
    total++; if (state_o !== 3'd1 || attempts !== 2'd3) begin bad++; $display("FAIL att_sat got=%0d/%0d want=1/3", state_o, attempts); end
  endtask
  task automatic test_complete();
    frame();
    lv.lv_cp = 3'b001; step(); lv.lv_cp = 0;
    total++; if (state_o !== 3'd4 || rgb !== 12'h1A3) begin bad++; $display("FAIL done_entry got=%0d/%h want=4/1a3", state_o, rgb); end
    frames(59);
    restart = 1; imgReturn = 1; step(); restart = 0; imgReturn = 0;
    total++; if (state_o !== 3'd1 || lv.lv_sel !== 2'd0) begin bad++; $display("FAIL done_restart got=%0d/%0d want=1/0", state_o, lv.lv_sel); end
    frame();
    lv.lv_cp = 3'b001; step(); lv.lv_cp = 0;
    frames(59);
    total++; if (state_o !== 3'd4) begin bad++; $display("FAIL done_f59 got=%0d want=4", state_o); end
    frame();
    total++; if (state_o !== 3'd1 || lv.lv_sel !== 2'd1) begin bad++; $display("FAIL advance1 got=%0d/%0d want=1/1", state_o, lv.lv_sel); end
    frame();
    total++; if (lv.lv_rst !== 3'b101 || rgb !== 12'h2B4) begin bad++; $display("FAIL play_lv1 got=%b/%h want=101/2b4", lv.lv_rst, rgb); end
    lv.lv_cp = 3'b010; step(); lv.lv_cp = 0;
    frames(60);
    frame();
    total++; if (state_o !== 3'd2 || lv.lv_sel !== 2'd2 || lv.lv_rst !== 3'b011 || rgb !== 12'h3C5) begin bad++; $display("FAIL play_lv2 got=%0d/%0d/%b/%h want=2/2/011/3c5", state_o, lv.lv_sel, lv.lv_rst, rgb); end
    lv.lv_cp = 3'b100; step(); lv.lv_cp = 0;
    frames(60);
    total++; if (state_o !== 3'd5 || rgb !== 12'hFFF || lv.lv_rst !== 3'b111) begin bad++; $display("FAIL win got=%0d/%h/%b want=5/fff/111", state_o, rgb, lv.lv_rst); end
    jump = 1; step(); jump = 0;
    total++; if (state_o !== 3'd0 || lv.lv_sel !== 2'd0 || attempts !== 2'd3 || rgb !== 12'h000) begin bad++; $display("FAIL win_exit got=%0d/%0d/%0d/%h want=0/0/3/000", state_o, lv.lv_sel, attempts, rgb); end
  endtask
  task automatic test_rst_mid();
    jump = 1; step(); jump = 0;
    total++; if (attempts !== 2'd1) begin bad++; $display("FAIL restart_game got=%0d want=1", attempts); end
    frame();
    lv.lv_death = 3'b001; step(); lv.lv_death = 0;
    frames(10);
    rst = 1; step(); rst = 0;
    total++; if (state_o !== 3'd0 || attempts !== 2'd0 || lv.lv_rst !== 3'b111 || rgb !== 12'h000) begin bad++; $display("FAIL rst_mid got=%0d/%0d/%b/%h want=0/0/111/000", state_o, attempts, lv.lv_rst, rgb); end
  endtask
  initial begin
    test_reset();
    test_start();
    test_death();
    test_priority();
    test_saturate();
    test_complete();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
